// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//
// Multi-cycle control sequencer for an RV32I core. It owns the program counter,
// the instruction register, the retired-instruction counter and the stage state
// machine (FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, TRAP). Memory accesses
// use a req/ready handshake with a bounded wait that raises a bus-timeout trap.
//
// Ports
//   CLK           in   rising-edge clock
//   BTN_N         in   asynchronous active-low reset
//   mem_rdata     in   read data from the load/store unit (instruction fetch)
//   mem_ready     in   access complete, only looked at while mem_req is high
//   alu_result    in   branch/jump target or effective address
//   branch_taken  in   comparator result for the current branch
//   resume        in   single-cycle pulse that leaves HALT
//   mem_req       out  memory access request (FETCH and MEM)
//   mem_wr        out  store access (MEM with a STORE)
//   mem_addr_sel  out  1: address is PC, 0: address is alu_result
//   instr         out  instruction register
//   pc            out  current program counter
//   reg_en        out  register file write strobe (one cycle per writer)
//   fetch_stage   out  high in FETCH
//   halted        out  high in HALT
//   trap          out  one-cycle pulse in TRAP
//   trap_cause    out  cause of the last trap (0 misaligned, 1 illegal,
//                      2 ecall, 3 bus timeout)
//   trap_pc       out  PC of the faulting instruction
//   instret       out  retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0010),
  parameter int              MEM_TIMEOUT  = 15
) (
  input  logic            CLK,
  input  logic            BTN_N,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] alu_result,
  input  logic            branch_taken,
  input  logic            resume,
  output logic            mem_req,
  output logic            mem_wr,
  output logic            mem_addr_sel,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic            reg_en,
  output logic            fetch_stage,
  output logic            halted,
  output logic            trap,
  output logic [1:0]      trap_cause,
  output logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] instret
);

  // Wait counter is sized to hold MEM_TIMEOUT; a disabled timeout keeps a
  // 1-bit counter that never counts.
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam int WAIT_W     = TIMEOUT_EN ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] CAUSE_MISALIGN = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CAUSE_ECALL    = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT,
    S_TRAP
  } state_t;

  state_t              r_state;
  logic [XLEN-1:0]     r_pc;
  logic [31:0]         r_instr;
  logic [XLEN-1:0]     r_instret;
  logic [1:0]          r_trap_cause;
  logic [XLEN-1:0]     r_trap_pc;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                r_redirect;
  logic [XLEN-1:0]     r_target;

  state_t              w_state_nxt;
  logic                w_pc_load;
  logic [XLEN-1:0]     w_pc_nxt;
  logic                w_retire;
  logic                w_instr_load;
  logic                w_trap_enter;
  logic [1:0]          w_trap_cause_nxt;
  logic [WAIT_W-1:0]   w_wait_nxt;

  // ---------------------------------------------------------------------------
  // Instruction classification
  // ---------------------------------------------------------------------------
  logic [6:0]      w_op;
  logic [11:0]     w_sys_funct;
  logic            w_is_load;
  logic            w_is_store;
  logic            w_is_branch;
  logic            w_is_jal;
  logic            w_is_jalr;
  logic            w_is_system;
  logic            w_legal;
  logic            w_ctrl_xfer;
  logic            w_misaligned;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_mem_phase;
  logic            w_timeout;

  assign w_op        = r_instr[6:0];
  assign w_sys_funct = r_instr[31:20];
  assign w_is_load   = (w_op == OP_LOAD);
  assign w_is_store  = (w_op == OP_STORE);
  assign w_is_branch = (w_op == OP_BRANCH);
  assign w_is_jal    = (w_op == OP_JAL);
  assign w_is_jalr   = (w_op == OP_JALR);
  assign w_is_system = (w_op == OP_SYSTEM);

  always_comb begin
    case (w_op)
      OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
      OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_SYSTEM: w_legal = 1'b1;
      default:                                    w_legal = 1'b0;
    endcase
  end

  assign w_ctrl_xfer = w_is_jal | w_is_jalr | (w_is_branch & branch_taken);
  // JALR drops bit 0 of its target before the alignment check.
  assign w_misaligned = w_is_jalr ? alu_result[1] : (alu_result[1:0] != 2'b00);
  assign w_target     = {alu_result[XLEN-1:1], 1'b0};
  assign w_pc_plus4   = r_pc + XLEN'(4);

  // ---------------------------------------------------------------------------
  // Bus wait limit. mem_ready on the limit cycle wins over the timeout.
  // ---------------------------------------------------------------------------
  assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_timeout   = TIMEOUT_EN && w_mem_phase && !mem_ready &&
                       (r_wait_cnt == WAIT_W'(MEM_TIMEOUT));

  // ---------------------------------------------------------------------------
  // Next state, PC and bookkeeping
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first so that no
  // path through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_load        = 1'b0;
    w_pc_nxt         = r_pc;
    w_retire         = 1'b0;
    w_instr_load     = 1'b0;
    w_trap_enter     = 1'b0;
    w_trap_cause_nxt = CAUSE_MISALIGN;

    case (r_state)
      S_FETCH: begin
        if (mem_ready) begin
          w_instr_load = 1'b1;
          w_state_nxt  = S_DECODE;
        end else if (w_timeout) begin
          w_trap_enter     = 1'b1;
          w_trap_cause_nxt = CAUSE_TIMEOUT;
          w_state_nxt      = S_TRAP;
        end
      end

      S_DECODE: begin
        if (!w_legal) begin
          w_trap_enter     = 1'b1;
          w_trap_cause_nxt = CAUSE_ILLEGAL;
          w_state_nxt      = S_TRAP;
        end else if (w_is_system) begin
          if (w_sys_funct == 12'd1) begin
            w_state_nxt = S_HALT;
          end else begin
            w_trap_enter     = 1'b1;
            w_trap_cause_nxt = (w_sys_funct == 12'd0) ? CAUSE_ECALL : CAUSE_ILLEGAL;
            w_state_nxt      = S_TRAP;
          end
        end else begin
          w_state_nxt = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        if (w_is_load || w_is_store) begin
          w_state_nxt = S_MEM;
        end else if (w_ctrl_xfer && w_misaligned) begin
          w_trap_enter     = 1'b1;
          w_trap_cause_nxt = CAUSE_MISALIGN;
          w_state_nxt      = S_TRAP;
        end else begin
          w_state_nxt = S_WRITEBACK;
        end
      end

      S_MEM: begin
        if (mem_ready) begin
          if (w_is_store) begin
            w_retire    = 1'b1;
            w_pc_load   = 1'b1;
            w_pc_nxt    = w_pc_plus4;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_WRITEBACK;
          end
        end else if (w_timeout) begin
          w_trap_enter     = 1'b1;
          w_trap_cause_nxt = CAUSE_TIMEOUT;
          w_state_nxt      = S_TRAP;
        end
      end

      S_WRITEBACK: begin
        w_retire    = 1'b1;
        w_pc_load   = 1'b1;
        w_pc_nxt    = r_redirect ? r_target : w_pc_plus4;
        w_state_nxt = S_FETCH;
      end

      S_HALT: begin
        if (resume) begin
          w_pc_load   = 1'b1;
          w_pc_nxt    = w_pc_plus4;
          w_state_nxt = S_FETCH;
        end
      end

      S_TRAP: begin
        w_pc_load   = 1'b1;
        w_pc_nxt    = TRAP_VECTOR;
        w_state_nxt = S_FETCH;
      end

      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Counter runs only while waiting in the same FETCH/MEM visit, so any entry
  // into FETCH or MEM starts it from zero.
  always_comb begin
    w_wait_nxt = '0;
    if (TIMEOUT_EN && w_mem_phase && (w_state_nxt == r_state)) begin
      w_wait_nxt = r_wait_cnt + WAIT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State and architectural registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge BTN_N) begin
    if (!BTN_N) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_VECTOR;
      r_instr      <= NOP_INSTR;
      r_instret    <= '0;
      r_trap_cause <= CAUSE_MISALIGN;
      r_trap_pc    <= '0;
      r_wait_cnt   <= '0;
      r_redirect   <= 1'b0;
      r_target     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_instr_load) r_instr   <= mem_rdata[31:0];
      if (w_pc_load)    r_pc      <= w_pc_nxt;
      if (w_retire)     r_instret <= r_instret + XLEN'(1);
      // Cause and faulting PC are captured on entry so they are valid while
      // the trap pulse is high.
      if (w_trap_enter) begin
        r_trap_cause <= w_trap_cause_nxt;
        r_trap_pc    <= r_pc;
      end
      // The redirect decision is frozen in EXECUTE; in WRITEBACK the ALU is
      // free to produce the link value instead of the target.
      if (r_state == S_EXECUTE) begin
        r_redirect <= w_ctrl_xfer;
        r_target   <= w_target;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Stage strobes are qualified with BTN_N so a reset mid-access drops
  // the request at once, without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_addr_sel = 1'b1;
    reg_en       = 1'b0;
    fetch_stage  = 1'b0;
    halted       = 1'b0;
    trap         = 1'b0;
    if (BTN_N) begin
      case (r_state)
        S_FETCH: begin
          mem_req     = 1'b1;
          fetch_stage = 1'b1;
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b0;
          mem_wr       = w_is_store;
        end
        S_WRITEBACK: reg_en = !w_is_branch && (r_instr[11:7] != 5'd0);
        S_HALT:      halted = 1'b1;
        S_TRAP:      trap   = 1'b1;
        default: ;
      endcase
    end
  end

  assign instr      = r_instr;
  assign pc         = r_pc;
  assign instret    = r_instret;
  assign trap_cause = r_trap_cause;
  assign trap_pc    = r_trap_pc;

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for cpu_sequencer. The bench plays the memory and datapath. For every
// instruction a transaction-level model expands the instruction into the list
// of cycles it must take (fetch waits, decode, execute, memory waits,
// writeback, halt, trap) with the outputs each cycle must show, and updates
// the architectural state (pc, instret, trap info). A compare process checks
// the DUT against that list on every falling edge. Directed cases add literal
// expectations that pin the model.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

  localparam int          XLEN = 32;
  localparam int          TO   = 15;
  localparam logic [31:0] TVEC = 32'h0000_0010;

  logic            CLK;
  logic            BTN_N;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;
  logic [XLEN-1:0] alu_result;
  logic            branch_taken;
  logic            resume;
  logic            mem_req;
  logic            mem_wr;
  logic            mem_addr_sel;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic            reg_en;
  logic            fetch_stage;
  logic            halted;
  logic            trap;
  logic [1:0]      trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] instret;

  cpu_sequencer #(
    .XLEN         (XLEN),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (TVEC),
    .MEM_TIMEOUT  (TO)
  ) dut (
    .CLK          (CLK),
    .BTN_N        (BTN_N),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .alu_result   (alu_result),
    .branch_taken (branch_taken),
    .resume       (resume),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_addr_sel (mem_addr_sel),
    .instr        (instr),
    .pc           (pc),
    .reg_en       (reg_en),
    .fetch_stage  (fetch_stage),
    .halted       (halted),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .trap_pc      (trap_pc),
    .instret      (instret)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected appearance of one clock cycle.
  typedef struct {
    logic        req;
    logic        sel;
    logic        wr;
    logic        wen;
    logic        fetch;
    logic        halt;
    logic        trp;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] ret;
    logic [1:0]  tc;
    logic [31:0] tpc;
    bit          chk_ti;
  } exp_t;

  exp_t exp_q[$];

  // Architectural state of the model.
  logic [31:0] m_pc, m_instr, m_instret, m_tpc;
  logic [1:0]  m_tcause;

  // Event counters on DUT strobes, used by the directed literal checks.
  int n_reg_en = 0;
  int n_trap   = 0;

  always @(negedge CLK) begin
    if (BTN_N) begin
      if (reg_en) n_reg_en++;
      if (trap)   n_trap++;
    end
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("mem_req",      32'(mem_req),      32'(e.req));
      check("mem_addr_sel", 32'(mem_addr_sel), 32'(e.sel));
      check("mem_wr",       32'(mem_wr),       32'(e.wr));
      check("reg_en",       32'(reg_en),       32'(e.wen));
      check("fetch_stage",  32'(fetch_stage),  32'(e.fetch));
      check("halted",       32'(halted),       32'(e.halt));
      check("trap",         32'(trap),         32'(e.trp));
      check("pc",           pc,                e.pc);
      check("instr",        instr,             e.ins);
      check("instret",      instret,           e.ret);
      if (e.chk_ti) begin
        check("trap_cause", 32'(trap_cause),   32'(e.tc));
        check("trap_pc",    trap_pc,           e.tpc);
      end
    end
  end

  function automatic bit is_legal(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1110011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t base_exp();
    exp_t e;
    e.req = 0; e.sel = 1; e.wr = 0; e.wen = 0; e.fetch = 0; e.halt = 0; e.trp = 0;
    e.pc = m_pc; e.ins = m_instr; e.ret = m_instret; e.tc = m_tcause; e.tpc = m_tpc;
    e.chk_ti = 1;
    return e;
  endfunction

  // One clock of stimulus plus the cycle the model expects. Called at posedge+1.
  task automatic cyc(input exp_t e, input logic rdy, input logic res, inout int n);
    mem_ready = rdy;
    resume    = res;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    n++;
  endtask

  task automatic model_trap(input logic [1:0] c, inout int n);
    exp_t e;
    e = base_exp();
    e.trp = 1; e.chk_ti = 0;
    cyc(e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n);
    m_tcause = c;
    m_tpc    = m_pc;
    m_pc     = TVEC;
  endtask

  // Runs one instruction end to end. wf/wm: low cycles of mem_ready before it
  // rises in fetch/mem (> TO means it never rises). nh: halt cycles before resume.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] alu, input logic tk,
                           input int wf, input int wm, input int nh, output int ncyc);
    exp_t        e;
    logic [6:0]  op;
    bit          ctrl, mis, ldst, is_st;
    logic [31:0] tgt;
    int          n;
    n = 0;
    mem_rdata = ins; alu_result = alu; branch_taken = tk;
    op = ins[6:0];
    for (int i = 0; i < ((wf > TO) ? TO + 1 : wf + 1); i++) begin
      e = base_exp(); e.req = 1; e.fetch = 1;
      cyc(e, (wf <= TO) && (i == wf), 1'($urandom_range(0, 1)), n);
    end
    if (wf > TO) begin
      model_trap(2'd3, n); ncyc = n; return;
    end
    m_instr = ins;
    cyc(base_exp(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n);  // decode
    if (!is_legal(op)) begin
      model_trap(2'd1, n); ncyc = n; return;
    end
    if (op == 7'b1110011) begin
      if (ins[31:20] == 12'd1) begin
        for (int i = 0; i <= nh; i++) begin
          e = base_exp(); e.halt = 1;
          cyc(e, 1'($urandom_range(0, 1)), i == nh, n);
        end
        m_pc = m_pc + 32'd4;
      end else begin
        model_trap((ins[31:20] == 12'd0) ? 2'd2 : 2'd1, n);
      end
      ncyc = n; return;
    end
    cyc(base_exp(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n);  // execute
    ctrl  = (op == 7'b1101111) || (op == 7'b1100111) || ((op == 7'b1100011) && tk);
    tgt   = alu & ~32'd1;
    mis   = (op == 7'b1100111) ? (tgt[1:0] != 0) : (alu[1:0] != 0);
    ldst  = (op == 7'b0000011) || (op == 7'b0100011);
    is_st = (op == 7'b0100011);
    if (!ldst && ctrl && mis) begin
      model_trap(2'd0, n); ncyc = n; return;
    end
    if (ldst) begin
      for (int i = 0; i < ((wm > TO) ? TO + 1 : wm + 1); i++) begin
        e = base_exp(); e.req = 1; e.sel = 0; e.wr = is_st;
        cyc(e, (wm <= TO) && (i == wm), 1'($urandom_range(0, 1)), n);
      end
      if (wm > TO) begin
        model_trap(2'd3, n); ncyc = n; return;
      end
      if (is_st) begin
        m_pc = m_pc + 32'd4; m_instret++; ncyc = n; return;
      end
    end
    e = base_exp();
    e.wen = (op != 7'b1100011) && (ins[11:7] != 5'd0);
    cyc(e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n);  // writeback
    m_pc = (!ldst && ctrl) ? tgt : m_pc + 32'd4;
    m_instret++;
    ncyc = n;
  endtask

  task automatic do_reset();
    BTN_N = 1'b0; mem_ready = 1'b0; resume = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    exp_q.delete();
    m_pc = 32'h0; m_instr = 32'h0000_0013; m_instret = 0; m_tcause = 0; m_tpc = 0;
    BTN_N = 1'b1;
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 31);
    if (r < 20)  return 0;
    if (r < 28)  return $urandom_range(1, 4);
    if (r == 28) return TO;
    if (r == 29) return TO - 1;
    if (r == 30) return TO + 1;
    return 0;
  endfunction

  function automatic logic [31:0] pick_instr();
    logic [31:0] ins;
    logic [6:0]  op;
    int          k;
    ins = $urandom;
    k   = $urandom_range(0, 15);
    case (k)
      0, 1:   op = 7'b0000011;
      2, 3:   op = 7'b0100011;
      4, 5:   op = 7'b1100011;
      6:      op = 7'b1101111;
      7:      op = 7'b1100111;
      8, 9:   op = 7'b0110011;
      10, 15: op = 7'b0010011;
      11:     op = 7'b0110111;
      12:     op = 7'b0010111;
      13:     op = 7'b1110011;
      default: op = 7'($urandom);
    endcase
    ins[6:0] = op;
    if (op == 7'b1110011) begin
      case ($urandom_range(0, 2))
        0: ins[31:20] = 12'd0;
        1: ins[31:20] = 12'd1;
        default: ;
      endcase
    end
    if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
    return ins;
  endfunction

  int          nc;
  int          base_reg, base_trap;
  logic [31:0] alu, ins, saved_pc, saved_ret;

  initial begin
    BTN_N = 1'b0; mem_ready = 1'b0; resume = 1'b0;
    mem_rdata = '0; alu_result = '0; branch_taken = 1'b0;

    // Reset values while BTN_N is held low.
    #13;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_sel", 32'(mem_addr_sel), 32'd1);
    check("rst_mem_wr",  32'(mem_wr), 32'd0);
    check("rst_reg_en",  32'(reg_en), 32'd0);
    check("rst_trap",    32'(trap), 32'd0);
    check("rst_halted",  32'(halted), 32'd0);
    check("rst_pc",      pc, 32'd0);
    check("rst_instr",   instr, 32'h0000_0013);
    check("rst_instret", instret, 32'd0);
    check("rst_tcause",  32'(trap_cause), 32'd0);
    check("rst_tpc",     trap_pc, 32'd0);
    do_reset();

    // addi x1,x0,5 at zero wait.
    base_reg = n_reg_en;
    run_instr(32'h0050_0093, 32'h0, 1'b0, 0, 0, 0, nc);
    check("addi_cycles", 32'(nc), 32'd4);
    check("addi_pc", pc, 32'd4);
    check("addi_instret", instret, 32'd1);
    check("addi_reg_en_pulses", 32'(n_reg_en - base_reg), 32'd1);

    // Misaligned JAL from PC 0.
    do_reset();
    base_trap = n_trap;
    run_instr(32'h0000_006F, 32'h0000_0102, 1'b0, 0, 0, 0, nc);
    check("jal_trap_pulses", 32'(n_trap - base_trap), 32'd1);
    check("jal_cause", 32'(trap_cause), 32'd0);
    check("jal_trap_pc", trap_pc, 32'd0);
    check("jal_next_pc", pc, 32'h10);
    check("jal_instret", instret, 32'd0);

    // Load with three wait states in MEM.
    base_reg = n_reg_en;
    run_instr(32'h0000_2283, 32'h0000_0040, 1'b0, 0, 3, 0, nc);
    check("load_cycles", 32'(nc), 32'd8);
    check("load_reg_en_pulses", 32'(n_reg_en - base_reg), 32'd1);
    check("load_pc", pc, 32'h14);

    // Fetch never answered: trap on the 16th request cycle.
    run_instr(32'h0050_0093, 32'h0, 1'b0, 100, 0, 0, nc);
    check("timeout_cycles", 32'(nc), 32'd17);
    check("timeout_cause", 32'(trap_cause), 32'd3);
    check("timeout_trap_pc", trap_pc, 32'h14);

    // mem_ready on exactly the limit cycle.
    base_trap = n_trap;
    run_instr(32'h0070_0113, 32'h0, 1'b0, TO, 0, 0, nc);
    check("edge_cycles", 32'(nc), 32'd19);
    check("edge_instr", instr, 32'h0070_0113);
    check("edge_no_trap", 32'(n_trap - base_trap), 32'd0);

    // EBREAK halts until resume, then PC advances by 4.
    saved_pc = pc; saved_ret = instret;
    run_instr(32'h0010_0073, 32'h0, 1'b0, 0, 0, 5, nc);
    check("ebreak_cycles", 32'(nc), 32'd8);
    check("ebreak_pc", pc, saved_pc + 32'd4);
    check("ebreak_instret", instret, saved_ret);

    // Illegal opcode.
    run_instr(32'h0000_007F, 32'h0, 1'b0, 0, 0, 0, nc);
    check("illegal_cause", 32'(trap_cause), 32'd1);

    // PC wrap through all-ones-minus-3.
    run_instr(32'h0000_006F, 32'hFFFF_FFFC, 1'b0, 0, 0, 0, nc);
    check("wrap_jump_pc", pc, 32'hFFFF_FFFC);
    saved_ret = instret;
    run_instr(32'h0000_0013, 32'h0, 1'b0, 0, 0, 0, nc);
    check("wrap_pc", pc, 32'h0);
    check("wrap_instret", instret, saved_ret + 32'd1);

    // Randomised instruction stream.
    for (int i = 0; i < 400; i++) begin
      ins = pick_instr();
      alu = $urandom;
      if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      run_instr(ins, alu, 1'($urandom_range(0, 1)), pick_wait(), pick_wait(),
                $urandom_range(0, 4), nc);
    end
    @(negedge CLK);
    #1;

    // Reset asserted in the middle of a load's MEM wait.
    do_reset();
    mem_rdata = 32'h0000_2283; alu_result = 32'h40; mem_ready = 1'b1;
    @(posedge CLK);
    #1;
    mem_ready = 1'b0;
    for (int i = 0; i < 8 && !(mem_req && !mem_addr_sel); i++) begin
      @(posedge CLK);
      #1;
    end
    check("reach_mem", 32'(mem_req && !mem_addr_sel), 32'd1);
    #2;
    BTN_N = 1'b0;
    #1;
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_mem_sel", 32'(mem_addr_sel), 32'd1);
    check("midrst_pc", pc, 32'd0);
    check("midrst_instr", instr, 32'h0000_0013);
    #10;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Parametrised multi-cycle control sequencer for the RV32I core: owns the program counter, instruction register and stage state machine. It replaces the fixed-latency fetch/execute control in the decoder path with a memory handshake, a bus timeout, trap and halt handling, and a retired-instruction counter. It sits between the load/store unit, which returns `mem_ready`, and the datapath: the ALU supplies targets and addresses, and the branch comparator supplies `branch_taken`.

## Interface
- `XLEN`, 32: data/address width.
- `RESET_VECTOR`, 32'h0000_0000: PC after reset.
- `TRAP_VECTOR`, 32'h0000_0010: PC loaded on any trap.
- `MEM_TIMEOUT`, 15: maximum wait cycles for `mem_ready`; 0 disables the timeout.

Ports:
- `CLK` in 1: single clock, rising edge.
- `BTN_N` in 1: reset, asynchronous, active-low.
- `mem_rdata` in XLEN: read data from the load/store unit.
- `mem_ready` in 1: access complete; sampled only while `mem_req`=1.
- `alu_result` in XLEN: branch/jump target or effective address.
- `branch_taken` in 1: comparator result for the current branch.
- `resume` in 1: single-cycle pulse that leaves HALT.
- `mem_req` out 1: memory access request.
- `mem_wr` out 1: store access.
- `mem_addr_sel` out 1: 1 selects PC as address, 0 selects `alu_result`.
- `instr` out 32: instruction register.
- `pc` out XLEN: current PC.
- `reg_en` out 1: register file write strobe.
- `fetch_stage` out 1: high in FETCH.
- `halted` out 1: high in HALT.
- `trap` out 1: one-cycle pulse in TRAP.
- `trap_cause` out 2: cause of the last trap.
- `trap_pc` out XLEN: PC of the faulting instruction.
- `instret` out XLEN: retired-instruction count.

## Operation
- **States:** FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, TRAP.
- **FETCH:**
  - Drives `mem_req`=1, `mem_addr_sel`=1.
  - On `mem_ready`: `instr`<=`mem_rdata`, go to DECODE.
- **DECODE:** classifies `instr[6:0]`.
  - Legal opcodes: LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111, SYSTEM 1110011.
  - Unknown opcode -> TRAP, cause 1.
  - SYSTEM with `instr[31:20]`=1 (EBREAK) -> HALT.
  - SYSTEM with `instr[31:20]`=0 (ECALL) -> TRAP, cause 2.
  - Any other SYSTEM -> TRAP, cause 1.
  - Everything else -> EXECUTE.
- **EXECUTE:**
  - LOAD/STORE -> MEM.
  - Control transfer with `alu_result[1:0]`!=0 -> TRAP, cause 0. A control transfer is JAL, JALR, or a BRANCH with `branch_taken`. For JALR, bit 0 is cleared before this check.
  - Otherwise -> WRITEBACK.
- **MEM:**
  - Drives `mem_req`=1, `mem_addr_sel`=0, `mem_wr`=(STORE).
  - On `mem_ready`: LOAD -> WRITEBACK; STORE retires and goes to FETCH.
- **WRITEBACK:**
  - `reg_en`=1 unless the opcode is BRANCH or `instr[11:7]`=0.
  - Retires, then -> FETCH.
- **PC update on retire:**
  - Taken branch, JAL or JALR: `pc`<={`alu_result`[XLEN-1:1],1'b0}.
  - Otherwise: `pc`<=`pc`+4, modulo 2^XLEN, so it wraps from all-ones-minus-3 to 0.
- **Retire counter:** `instret` increments by 1 per retire and wraps to 0.
- **HALT:**
  - `halted`=1, and `resume` is sampled only in this state.
  - On `resume`: `pc`<=`pc`+4, go to FETCH.
  - EBREAK does not retire.
- **TRAP (one cycle):**
  - `trap`=1.
  - `trap_pc`<=faulting `pc`, `trap_cause` is latched, `pc`<=`TRAP_VECTOR`.
  - Then -> FETCH. `instret` is unchanged.
- **Bus timeout:**
  - A wait counter clears on entry to FETCH/MEM and increments each cycle `mem_ready`=0.
  - When it equals `MEM_TIMEOUT` with `mem_ready` still 0 -> TRAP, cause 3.
  - If `mem_ready` and the limit occur in the same cycle, `mem_ready` wins.
  - The counter width is clog2(`MEM_TIMEOUT`+1).

## Timing
- **Reset values:**
  - `pc`=`RESET_VECTOR`, `instr`=32'h0000_0013, state FETCH.
  - `mem_req`=`mem_wr`=`reg_en`=`trap`=`halted`=0, `mem_addr_sel`=1.
  - `trap_cause`=0, `trap_pc`=0, `instret`=0.
  - `fetch_stage`=1 once out of reset.
- **Reset assertion:** all outputs take their reset values immediately, independent of `CLK`, including mid-access. A pending request is dropped, not completed.
- **Handshake:** `mem_req` and `mem_ready` may be high in the same cycle, giving a zero-wait access. `mem_req` and the address stay stable until the `mem_ready` cycle.
- **Cycle counts at zero wait:**
  - ALU/LUI/AUIPC/branch/jump: 4 cycles (F, D, E, W).
  - LOAD: 5 cycles (F, D, E, M, W).
  - STORE: 4 cycles (F, D, E, M).
  - Each wait cycle adds 1.
- **Output timing:** `reg_en` is high for exactly one cycle per writing instruction. `pc` changes on the edge leaving WRITEBACK, MEM (store), HALT or TRAP.

## Test plan
- **ALU op + counter:** reset, zero-wait memory returns `addi x1,x0,5` at PC 0 -> 4 cycles, `reg_en` one pulse in WRITEBACK, `pc`=4, `instret`=1.
- **Misaligned jump:** JAL with `alu_result`=32'h102 -> `trap`=1, `trap_cause`=0, `trap_pc`=0, next fetch at 32'h10.
- **Load with wait states:** `mem_ready` held low 3 cycles in MEM -> 8 total cycles, `mem_addr_sel`=0 throughout MEM, `reg_en`=1 once.
- **Bus timeout:** `mem_ready` never asserts in FETCH with `MEM_TIMEOUT`=15 -> TRAP on the 16th request cycle, cause 3.
- **Timeout edge:** `mem_ready` on exactly the limit cycle -> no trap, instruction latched.
- **Halt, illegal opcode and reset:**
  - EBREAK -> `halted`=1 and stays until `resume`, then `pc` +=4.
  - Opcode 7'b1111111 -> cause 1.
  - `BTN_N` low mid-MEM -> `mem_req`=0 immediately, `pc`=`RESET_VECTOR`.
